regfile_sb: RTL

//  Parametrised integer register file with per-register write scoreboard and registered ecall-halt detect.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 76 +++++++
 rtl/regfile_sb.sv | 80 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared parameters and types for the pipelined-core register file.
// Contents: XLEN, NREGS, AW, MAX_PEND, PW, SP_INIT, HALT_REG, HALT_CODE,
//           reg_addr_t (register index) and xword_t (data word).
package regfile_pkg;
    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int AW        = $clog2(NREGS);
    localparam int MAX_PEND  = 3;
    localparam int PW        = $clog2(MAX_PEND + 1);
    localparam logic [XLEN-1:0] SP_INIT   = 32'h2ffc;
    localparam logic [AW-1:0]   HALT_REG  = AW'(17);
    localparam logic [XLEN-1:0] HALT_CODE = XLEN'(10);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;
    typedef logic [PW-1:0]   pend_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register in-flight write counters for the register file.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   halted            machine halted: issues and writebacks have no effect
//   issue_valid/rd    reservation request from ID; issue_ready = accepted
//   wb_valid/wb_rd    writeback strobe and address from WB
//   rs1, rs2          operand addresses; rs1_busy/rs2_busy lookups
//   halt_busy         busy lookup for the halt-compare register
//   sb_error          sticky: writeback seen while the count was zero
// Build option: REGFILE_BYPASS_EN lets a same-cycle writeback clear busy
// when it retires the last pending write.
import regfile_pkg::*;

module rf_scoreboard (
    input  logic      clk,
    input  logic      reset,
    input  logic      halted,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    output logic      issue_ready,
    input  logic      wb_valid,
    input  reg_addr_t wb_rd,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      halt_busy,
    output logic      sb_error
);
    pend_t pend [NREGS];

    // Writebacks to x0 and writebacks while halted never touch the counters.
    logic wb_eff;
    logic issue_acc;
    assign wb_eff    = wb_valid && (wb_rd != '0) && !halted;
    assign issue_acc = issue_valid && issue_ready && (issue_rd != '0);

    // A full counter can still accept when this cycle's writeback frees a slot.
    assign issue_ready = !halted && ((issue_rd == '0) ||
                         (pend[issue_rd] != pend_t'(MAX_PEND)) ||
                         (wb_eff && (wb_rd == issue_rd)));

    function automatic logic busy_of(input reg_addr_t r);
`ifdef REGFILE_BYPASS_EN
        return (pend[r] != '0) &&
               !((pend[r] == pend_t'(1)) && wb_eff && (wb_rd == r));
`else
        return pend[r] != '0;
`endif
    endfunction

    assign rs1_busy  = busy_of(rs1);
    assign rs2_busy  = busy_of(rs2);
    assign halt_busy = busy_of(HALT_REG);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) pend[r] <= '0;
            sb_error <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (r != 0) begin
                    // Simultaneous issue and retire of the same register cancel.
                    if (issue_acc && (issue_rd == reg_addr_t'(r)) &&
                        !(wb_eff && (wb_rd == reg_addr_t'(r)))) begin
                        pend[r] <= pend[r] + pend_t'(1);
                    end else if (wb_eff && (wb_rd == reg_addr_t'(r)) &&
                                 !(issue_acc && (issue_rd == reg_addr_t'(r)))) begin
                        if (pend[r] != '0) pend[r] <= pend[r] - pend_t'(1);
                        else               sb_error <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write scoreboard and registered ecall-halt.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   rs1, rs2              read addresses; rs1_dout/rs2_dout combinational data
//   rs1_busy, rs2_busy    operand has pending writes
//   issue_valid/issue_rd  reserve rd at issue; issue_ready = reservation accepted
//   wb_valid/wb_rd/rd_din writeback from WB stage
//   is_ecall              ecall in ID; is_halted sticky halt flag
//   sb_error              sticky writeback-without-reservation flag
// Build option: REGFILE_BYPASS_EN enables same-cycle write-through on reads,
// busy flags and the halt compare.
import regfile_pkg::*;

module regfile_sb (
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output xword_t    rs1_dout,
    output xword_t    rs2_dout,
    output logic      rs1_busy,
    output logic      rs2_busy,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    output logic      issue_ready,
    input  logic      wb_valid,
    input  reg_addr_t wb_rd,
    input  xword_t    rd_din,
    input  logic      is_ecall,
    output logic      is_halted,
    output logic      sb_error
);
    xword_t rf [NREGS];
    logic   halt_busy;
    logic   wb_eff;
    xword_t halt_val;

    assign wb_eff = wb_valid && (wb_rd != '0) && !is_halted;

    rf_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .halted      (is_halted),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .halt_busy   (halt_busy),
        .sb_error    (sb_error)
    );

    function automatic xword_t read_port(input reg_addr_t a);
        if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb_eff && (wb_rd == a)) return rd_din;
`endif
        return rf[a];
    endfunction

    assign rs1_dout = read_port(rs1);
    assign rs2_dout = read_port(rs2);
    assign halt_val = read_port(HALT_REG);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) rf[r] <= '0;
            rf[2]     <= SP_INIT;
            is_halted <= 1'b0;
        end else begin
            if (wb_eff) rf[wb_rd] <= rd_din;
            if (is_ecall && !halt_busy && (halt_val == HALT_CODE))
                is_halted <= 1'b1;
        end
    end
endmodule
